// File: rtl/mod3_sched_if.sv
// mod3_sched_if: requester-side bus of the shared mod-3 scheduler.
// The master side is the requester logic (drives req/data). The slave side is the scheduler.
// The rem field exists only when MOD3_SCHED_REM_OUT_EN is defined.
interface mod3_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    done;
    logic [$clog2(NREQ)-1:0] done_id;
    logic                    div3;
`ifdef MOD3_SCHED_REM_OUT_EN
    logic [1:0]              rem;

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, div3, rem
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, div3, rem
    );
`else
    modport master (
        output req, data,
        input  gnt, busy, done, done_id, div3
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, div3
    );
`endif
endinterface

// File: rtl/mod3_sched.sv
// mod3_sched: round-robin arbiter sharing one bit-serial divide-by-3 remainder engine.
// A granted word is shifted MSB-first through a one-hot remainder FSM, one bit per clock.
// done fires WIDTH cycles after the grant pulse, and div3 reports divisibility by 3.
// Optional macro MOD3_SCHED_REM_OUT_EN adds the binary remainder output rem[1:0].
module mod3_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    mod3_sched_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    // One-hot remainder encodings
    localparam logic [2:0] R0 = 3'b001;
    localparam logic [2:0] R1 = 3'b010;
    localparam logic [2:0] R2 = 3'b100;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Computes rem' = (2*rem + b) mod 3 in one-hot form.
    // Any illegal encoding falls back to R0.
    function automatic logic [2:0] rem_step(input logic [2:0] r, input logic b);
        case (r)
            R0:      return b ? R1 : R0;
            R1:      return b ? R0 : R2;
            R2:      return b ? R2 : R1;
            default: return R0;
        endcase
    endfunction

`ifdef MOD3_SCHED_REM_OUT_EN
    // Converts a legal one-hot remainder to binary 0..2
    function automatic logic [1:0] rem_bin(input logic [2:0] r);
        return {r[2], r[1]};
    endfunction
`endif

    // Control state
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic             div3_q, div3_d;
`ifdef MOD3_SCHED_REM_OUT_EN
    logic [1:0]       rem_q, rem_d;
`endif

    // Datapath state
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [2:0]       racc_q, racc_d;

    // Arbitration result
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_word;

    // Remainder after consuming the current MSB
    logic [2:0]       rem_nxt;

    assign rem_nxt = rem_step(racc_q, sreg_q[WIDTH-1]);

    // Round-robin search starting just after the last winner, wrapping modulo NREQ
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = ptr_q;
        win_word  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
                win_word  = bus.data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and output logic of the IDLE/SHIFT controller
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        div3_d    = div3_q;
`ifdef MOD3_SCHED_REM_OUT_EN
        rem_d     = rem_q;
`endif
        sreg_d    = sreg_q;
        racc_d    = racc_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d         = SHIFT;
                    ptr_d           = win_idx;
                    gnt_d[win_idx]  = 1'b1;
                    sreg_d          = win_word;
                    racc_d          = R0;
                    cnt_d           = '0;
                end
            end
            SHIFT: begin
                racc_d = rem_nxt;
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the result and free the engine
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = ptr_q;
                    div3_d    = (rem_nxt == R0);
`ifdef MOD3_SCHED_REM_OUT_EN
                    rem_d     = rem_bin(rem_nxt);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any word in flight and restores requester-0 priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            div3_q    <= 1'b0;
`ifdef MOD3_SCHED_REM_OUT_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            div3_q    <= div3_d;
`ifdef MOD3_SCHED_REM_OUT_EN
            rem_q     <= rem_d;
`endif
        end
    end

    // Shift register and remainder accumulator; always reloaded at grant, so no reset
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
        racc_q <= racc_d;
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.div3    = div3_q;
`ifdef MOD3_SCHED_REM_OUT_EN
    assign bus.rem     = rem_q;
`endif

endmodule

// File: tb/tb_mod3_sched.sv
// tb_mod3_sched: directed bench for mod3_sched with a cycle-level reference model.
module tb_mod3_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod3_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    mod3_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word-level view, with a countdown of busy cycles and an arithmetic remainder
    int              m_left = 0;
    int              m_ptr  = NREQ - 1;
    int              m_word = 0;
    logic [NREQ-1:0] e_gnt  = '0;
    logic            e_done = 1'b0;
    logic            e_div3 = 1'b0;
    int              e_id   = 0;
    int              e_rem  = 0;
    bit              live   = 1'b0;

    always @(posedge clk) begin
        live = 1'b1;
        if (rst) begin
            m_left = 0;
            m_ptr  = NREQ - 1;
            e_gnt  = '0;
            e_done = 1'b0;
            e_div3 = 1'b0;
            e_id   = 0;
            e_rem  = 0;
        end else begin
            e_gnt  = '0;
            e_done = 1'b0;
            if (m_left == 0) begin
                if (bus.req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (bus.req[(m_ptr + k) % NREQ]) begin
                            m_ptr = (m_ptr + k) % NREQ;
                            break;
                        end
                    end
                    m_word = int'(bus.data[m_ptr*WIDTH +: WIDTH]);
                    e_gnt  = NREQ'(1) << m_ptr;
                    m_left = WIDTH;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    e_done = 1'b1;
                    e_id   = m_ptr;
                    e_rem  = m_word % 3;
                    e_div3 = (e_rem == 0);
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (live) begin
            check("m_gnt",     bus.gnt,     e_gnt);
            check("m_busy",    bus.busy,    m_left != 0);
            check("m_done",    bus.done,    e_done);
            check("m_done_id", bus.done_id, e_id);
            check("m_div3",    bus.div3,    e_div3);
`ifdef MOD3_SCHED_REM_OUT_EN
            check("m_rem",     bus.rem,     e_rem);
`endif
        end
    end

    // Advance one clock; the requester drops any bit it sees granted
    task automatic tick();
        @(posedge clk);
        #1;
        bus.req = bus.req & ~bus.gnt;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        bus.data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 40);
        check("gnt_wait", bus.gnt != '0, 1'b1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 40);
        check("done_wait", bus.done, 1'b1);
    endtask

    task automatic run_one(input int idx, input logic [WIDTH-1:0] v, input logic exp_div3, input int exp_rem);
        int n;
        set_word(idx, v);
        bus.req[idx] = 1'b1;
        wait_gnt(n);
        check("one_gnt", bus.gnt, NREQ'(1) << idx);
        wait_done(n);
        check("one_latency", n, WIDTH);
        check("one_done_id", bus.done_id, idx);
        check("one_div3", bus.div3, exp_div3);
        check("one_model_rem", e_rem, exp_rem);
`ifdef MOD3_SCHED_REM_OUT_EN
        check("one_rem", bus.rem, exp_rem);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        bus.req  = 4'b1111;
        bus.data = '0;
        set_word(0, 8'd6);

        // Reset held with all requests pending
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt",     bus.gnt,     4'b0000);
            check("rst_busy",    bus.busy,    1'b0);
            check("rst_done",    bus.done,    1'b0);
            check("rst_done_id", bus.done_id, 0);
            check("rst_div3",    bus.div3,    1'b0);
        end
        rst = 1'b0;
        tick();
        check("first_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        wait_done(n);
        check("first_done_id", bus.done_id, 0);
        check("first_div3", bus.div3, 1'b1);

        // Single words and remainder values
        run_one(2, 8'd9,   1'b1, 0);
        run_one(1, 8'd10,  1'b0, 1);
        run_one(0, 8'd11,  1'b0, 2);
        run_one(3, 8'd255, 1'b1, 0);

        // Round-robin with all requesters, then wrap after ptr=3
        set_word(0, 8'd12);
        set_word(1, 8'd13);
        set_word(2, 8'd14);
        set_word(3, 8'd15);
        bus.req = 4'b1111;
        wait_gnt(n);
        check("rr_gnt0", bus.gnt, 4'b0001);
        for (int j = 1; j < NREQ; j++) begin
            wait_gnt(n);
            check("rr_gnt", bus.gnt, NREQ'(1) << j);
            check("rr_spacing", n, WIDTH + 1);
        end
        bus.req = 4'b0011;
        wait_gnt(n);
        check("rr_wrap_gnt", bus.gnt, 4'b0001);
        check("rr_wrap_spacing", n, WIDTH + 1);
        wait_gnt(n);
        check("rr_wrap_gnt1", bus.gnt, 4'b0010);
        wait_done(n);
        check("rr_last_id", bus.done_id, 1);

        // Reset in the middle of a word
        set_word(2, 8'd5);
        bus.req[2] = 1'b1;
        wait_gnt(n);
        check("abort_gnt", bus.gnt, 4'b0100);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        bus.req = 4'b0101;
        wait_gnt(n);
        check("post_rst_gnt", bus.gnt, 4'b0001);
        check("post_rst_wait", n, 1);
        wait_done(n);
        check("post_rst_id0", bus.done_id, 0);
        wait_gnt(n);
        check("post_rst_gnt2", bus.gnt, 4'b0100);
        wait_done(n);
        check("post_rst_id2", bus.done_id, 2);
        check("post_rst_div3", bus.div3, 1'b0);

        // Back-to-back grant and a withdrawn request
        set_word(0, 8'd3);
        bus.req[0] = 1'b1;
        wait_gnt(n);
        check("b2b_gnt0", bus.gnt, 4'b0001);
        tick();
        tick();
        set_word(1, 8'd7);
        set_word(3, 8'd1);
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        tick();
        tick();
        bus.req[3] = 1'b0;
        wait_done(n);
        check("b2b_latency", n, WIDTH - 4);
        check("b2b_div3_0", bus.div3, 1'b1);
        tick();
        check("b2b_gnt1", bus.gnt, 4'b0010);
        wait_done(n);
        check("b2b_id1", bus.done_id, 1);
        check("b2b_div3_1", bus.div3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("no_gnt3", bus.gnt[3], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
